// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the ALU controller and multicycle_alu.
// The master drives the request, and multicycle_alu (the slave) returns status and result.
interface multicycle_alu_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Illegal;

    modport master (
        output start, Operation, A, B,
        input  busy, done, Result, Zero, Illegal
    );

    modport slave (
        input  start, Operation, A, B,
        output busy, done, Result, Zero, Illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: ADD/SUB/SLL/OR/AND on latched operands with registered Result/Zero/Illegal flags.
// Latency: done 2 cycles after start; iterative SLL by s>0 takes 1+s cycles (ALU_FAST_SHIFT_EN: 2 cycles always).
// Backpressure: none queued; start is ignored while busy or done is high.
module multicycle_alu #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_alu_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB_BR = 4'b0001;
    localparam logic [3:0] OP_ADD2   = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_OR     = 4'b0101;
    localparam logic [3:0] OP_AND    = 4'b0110;

    state_t           state_q, state_d;
    req_t             req_q, req_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic [WIDTH-1:0] shl1;

    // Single-cycle datapath used in EXEC on the latched request.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (req_q.op)
            OP_ADD, OP_ADD2:   alu_res = req_q.a + req_q.b;
            OP_SUB_BR, OP_SUB: alu_res = req_q.a - req_q.b;
            OP_SLL: begin
`ifdef ALU_FAST_SHIFT_EN
                alu_res = req_q.a << req_q.b[SHW-1:0];
`else
                // Only a zero shift amount reaches EXEC in the iterative build.
                alu_res = req_q.a;
`endif
            end
            OP_OR:             alu_res = req_q.a | req_q.b;
            OP_AND:            alu_res = req_q.a & req_q.b;
            default:           alu_ill = 1'b1;
        endcase
    end

    assign shl1 = {req_q.a[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    req_d = '{op: bus.Operation, a: bus.A, b: bus.B};
                    cnt_d = bus.B[SHW-1:0];
`ifdef ALU_FAST_SHIFT_EN
                    state_d = EXEC;
`else
                    if (bus.Operation == OP_SLL && bus.B[SHW-1:0] != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = EXEC;
                    end
`endif
                end
            end
            EXEC: begin
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                ill_d   = alu_ill;
                state_d = DONE;
            end
            SHIFT: begin
                req_d.a = shl1;
                cnt_d   = cnt_q - SHW'(1);
                // The last step publishes the shifted value directly, saving an EXEC pass.
                if (cnt_q == SHW'(1)) begin
                    res_d   = shl1;
                    zero_d  = (shl1 == '0);
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.busy    = (state_q == EXEC) || (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
    assign bus.Result  = res_q;
    assign bus.Zero    = zero_q;
    assign bus.Illegal = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: a transaction-level reference model checked every cycle, plus directed vectors.
// Build with +define+ALU_FAST_SHIFT_EN to exercise the barrel-shift variant.
module tb_multicycle_alu;

    localparam int WIDTH = 64;
    localparam int SHW   = 6;
`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(WIDTH)) bus();

    multicycle_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: one outstanding operation, committed at a computed edge.
    int          edge_cnt  = 0;
    int          next_acc  = 0;
    int          pend_edge = 0;
    bit          pend      = 1'b0;
    bit          chk_en    = 1'b0;
    logic [63:0] pend_res  = '0;
    bit          pend_ill  = 1'b0;
    logic [63:0] m_res     = '0;
    bit          m_zero    = 1'b1;
    bit          m_ill     = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;

    function automatic logic [64:0] spec_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd0, 4'd2: return {1'b0, a + b};
            4'd1, 4'd3: return {1'b0, a - b};
            4'd4:       return {1'b0, a << b[5:0]};
            4'd5:       return {1'b0, a | b};
            4'd6:       return {1'b0, a & b};
            default:    return {1'b1, 64'd0};
        endcase
    endfunction

    function automatic int op_latency(input logic [3:0] op, input logic [63:0] b);
        if (op == 4'd4 && !FAST && b[5:0] != 6'd0) return int'(b[5:0]) + 1;
        return 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " busy"},    {63'd0, bus.busy},    64'd0);
        chk({nm, " done"},    {63'd0, bus.done},    64'd0);
        chk({nm, " Result"},  bus.Result,           64'd0);
        chk({nm, " Zero"},    {63'd0, bus.Zero},    64'd1);
        chk({nm, " Illegal"}, {63'd0, bus.Illegal}, 64'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input bit ez, input bit ei, input int elat, input string nm);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.Operation = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.Operation = 4'hF; bus.A = ~a; bus.B = ~b;
        n = 1;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(elat));
        chk({nm, " Result"},  bus.Result, er);
        chk({nm, " Zero"},    {63'd0, bus.Zero},    {63'd0, ez});
        chk({nm, " Illegal"}, {63'd0, bus.Illegal}, {63'd0, ei});
        chk({nm, " model"},   m_res, er);
        @(negedge clk);
        chk({nm, " single done"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.Operation = 4'd0; bus.A = '0; bus.B = '0;
        fork
            forever begin
                @(posedge clk);
                edge_cnt++;
                m_done = 1'b0;
                if (reset) begin
                    chk_en = 1'b1; pend = 1'b0; m_busy = 1'b0;
                    m_res = '0; m_zero = 1'b1; m_ill = 1'b0;
                    next_acc = edge_cnt + 1;
                end else if (pend && edge_cnt == pend_edge) begin
                    m_res = pend_res; m_zero = (pend_res == 64'd0); m_ill = pend_ill;
                    m_done = 1'b1; m_busy = 1'b0; pend = 1'b0;
                    next_acc = edge_cnt + 2;
                end else if (!pend && bus.start && edge_cnt >= next_acc) begin
                    {pend_ill, pend_res} = spec_op(bus.Operation, bus.A, bus.B);
                    pend_edge = edge_cnt + op_latency(bus.Operation, bus.B) - 1;
                    pend = 1'b1; m_busy = 1'b1;
                end
            end
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    checks++;
                    if ({bus.busy, bus.done, bus.Result, bus.Zero, bus.Illegal} !==
                        {m_busy, m_done, m_res, m_zero, m_ill}) begin
                        errors++;
                        $display("FAIL cycle %0d busy/done/Result/Zero/Illegal: got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b",
                                 edge_cnt, bus.busy, bus.done, bus.Result, bus.Zero, bus.Illegal,
                                 m_busy, m_done, m_res, m_zero, m_ill);
                    end
                end
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk_reset_outputs("reset");
                reset = 1'b0;

                run_op(4'b0011, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 2, "sub_eq");
                run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 2, "add_wrap");
                run_op(4'b0000, 64'd7, 64'd8, 64'd15, 1'b0, 1'b0, 2, "add0");
                run_op(4'b0001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 2, "sub_br");
                run_op(4'b0100, 64'd1, 64'd3, 64'd8, 1'b0, 1'b0, FAST ? 2 : 4, "sll3");
                run_op(4'b0100, 64'd1, 64'd0, 64'd1, 1'b0, 1'b0, 2, "sll0");
                run_op(4'b0100, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 2, "sll1");
                run_op(4'b0100, 64'd5, 64'h43, 64'h28, 1'b0, 1'b0, FAST ? 2 : 4, "sll_hiB");
                run_op(4'b0100, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, FAST ? 2 : 64, "sll63");
                run_op(4'b0100, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b1, 1'b0, 2, "sll_out");
                run_op(4'b0101, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 2, "or");
                run_op(4'b1001, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 2, "illegal9");
                run_op(4'b0110, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 2, "and");
                run_op(4'b0111, 64'd1, 64'd1, 64'd0, 1'b1, 1'b1, 2, "illegal7");
                run_op(4'b1111, 64'd1, 64'd1, 64'd0, 1'b1, 1'b1, 2, "illegal15");
                run_op(4'b0101, 64'h1, 64'h2, 64'h3, 1'b0, 1'b0, 2, "or_after_ill");

                // Second start three cycles into a long shift must be dropped.
                begin
                    int pulses = 0;
                    @(negedge clk);
                    bus.start = 1'b1; bus.Operation = 4'b0100; bus.A = 64'h123; bus.B = 64'd10;
                    for (int i = 1; i <= 30; i++) begin
                        @(negedge clk);
                        bus.start = (i == 3);
                        if (i == 1) begin bus.A = 64'hDEAD; bus.B = 64'd1; end
                        if (i == 3) begin bus.Operation = 4'b0010; bus.A = 64'd1; bus.B = 64'd1; end
                        if (bus.done === 1'b1) pulses++;
                    end
                    chk("busy_start pulses", 64'(pulses), FAST ? 64'd2 : 64'd1);
                    chk("busy_start Result", bus.Result, FAST ? 64'd2 : 64'h48C00);
                end

                // Start held high: re-accepted only once the DUT is back in IDLE.
                begin
                    int pulses = 0;
                    @(negedge clk);
                    bus.start = 1'b1; bus.Operation = 4'b0000; bus.A = 64'd1; bus.B = 64'd2;
                    for (int i = 1; i <= 12; i++) begin
                        @(negedge clk);
                        if (i == 8) bus.start = 1'b0;
                        if (bus.done === 1'b1) pulses++;
                    end
                    chk("held_start pulses", 64'(pulses), 64'd3);
                    chk("held_start Result", bus.Result, 64'd3);
                end

                // Reset mid-shift aborts silently; a start alongside reset is dropped.
                begin
                    int pulses = 0;
                    @(negedge clk);
                    bus.start = 1'b1; bus.Operation = 4'b0100; bus.A = 64'hABC; bus.B = 64'd20;
                    for (int i = 1; i <= 5; i++) begin
                        @(negedge clk);
                        bus.start = 1'b0;
                        if (i == 5) begin
                            reset = 1'b1; bus.start = 1'b1;
                            bus.Operation = 4'b0010; bus.A = 64'd4; bus.B = 64'd4;
                        end
                    end
                    @(negedge clk);
                    reset = 1'b0; bus.start = 1'b0;
                    chk_reset_outputs("mid_reset");
                    for (int i = 0; i < 30; i++) begin
                        @(negedge clk);
                        if (bus.done === 1'b1) pulses++;
                    end
                    chk("mid_reset pulses", 64'(pulses), 64'd0);
                    chk("mid_reset Result", bus.Result, 64'd0);
                end
                run_op(4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 2, "after_reset");
                run_op(4'b0100, 64'd3, 64'd4, 64'h30, 1'b0, 1'b0, FAST ? 2 : 5, "sll4_after_reset");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits (power of two, 8..64).
REQ-002 Parameter SHW, default 6, shift-amount width (log2 WIDTH).
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, request pulse; sampled only in IDLE.
REQ-006 Port Operation, input, 4, operation code from ALU control.
REQ-007 Port A, input, WIDTH, operand 1.
REQ-008 Port B, input, WIDTH, operand 2; B[SHW-1:0] is the shift amount for SLL.
REQ-009 Port busy, output, 1, high while an accepted operation is in progress.
REQ-010 Port done, output, 1, one-cycle completion pulse.
REQ-011 Port Result, output, WIDTH, registered result.
REQ-012 Port Zero, output, 1, registered flag, high when Result == 0.
REQ-013 Port Illegal, output, 1, registered flag, high when the last accepted Operation was unsupported.

Function
REQ-014 Opcode map: 0000 ADD, 0001 SUB (branch compare), 0010 ADD, 0011 SUB, 0100 SLL, 0101 OR, 0110 AND; 0111-1111 illegal.
REQ-015 Arithmetic is modulo 2^WIDTH; carry/borrow discarded; no overflow flag.
REQ-016 States IDLE, EXEC, SHIFT, DONE; reset state IDLE.
REQ-017 IDLE with start=1: latch A, B, Operation into internal registers; go to SHIFT if SLL with shamt>0, else EXEC; busy rises next cycle.
REQ-018 EXEC: compute the latched op in one cycle; write Result, Zero, Illegal; go to DONE.
REQ-019 SHIFT: shift working register left 1 bit, decrement count per cycle; when count reaches 1, write final Result/Zero/Illegal and go to DONE.
REQ-020 DONE: done=1 for exactly this cycle, busy=0; return to IDLE next cycle; start is ignored in DONE.
REQ-021 Latency: start edge N -> done high during cycle N+2 for non-shift ops and SLL with shamt 0; cycle N+1+s for SLL with shamt s>0.
REQ-022 start while busy=1 or in DONE is ignored, with no queuing.
REQ-023 Operand inputs are not sampled after acceptance; input changes mid-operation do not affect Result.
REQ-024 Illegal op: Result=0, Zero=1, Illegal=1, normal EXEC latency.
REQ-025 Result, Zero, Illegal hold their values until the next operation completes.
REQ-026 SLL with shamt ≥ WIDTH cannot occur because shamt is SHW bits wide.

Reset
REQ-027 Reset (synchronous, active-high) forces IDLE, busy=0, done=0, Result=0, Zero=1, Illegal=0, and clears internal registers.
REQ-028 Reset asserted mid-operation aborts it with no done pulse; a start in the same cycle as reset is ignored.

Configuration
REQ-029 Macro ALU_FAST_SHIFT_EN: when defined, SLL uses a single-cycle barrel shift through EXEC and the SHIFT state is never entered (latency as other ops); when undefined, SLL is iterative per REQ-019.

Verification
REQ-030 reset held 2 cycles -> Result=0, Zero=1, busy=0, done=0, Illegal=0.
REQ-031 start, Op=0011, A=5, B=5 -> done 2 cycles after start, Result=0, Zero=1; Op=0010, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> Result=0, Zero=1.
REQ-032 start, Op=0100, A=1, B=3 -> done at start+4 (iterative) or start+2 (ALU_FAST_SHIFT_EN), Result=8, Zero=0; with B=0 -> Result=1 at start+2.
REQ-033 start accepted with SLL shamt 10, second start with Op=0010 issued 3 cycles later -> second start ignored, single done pulse, Result=A<<10.
REQ-034 Op=1001 -> Result=0, Zero=1, Illegal=1; then Op=0110, A=0xF0, B=0x3C -> Result=0x30, Illegal=0.
REQ-035 SLL shamt 20 started, reset asserted 5 cycles later -> no done pulse, outputs return to reset values, next start works normally.
